// File: rtl/spi_slave_fsm_burst.sv
// Control FSM for the SPI slave datapath: counts synchronised SCLK edges, decodes the
// address + R/W header and sequences the address latch, shift register, MISO enable and memory writes.
module spi_slave_fsm_burst #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_EN   = 1,
  localparam int CW = $clog2(((ADDR_WIDTH + 1) > DATA_WIDTH ? (ADDR_WIDTH + 1) : DATA_WIDTH) + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sclk_edge,
  input  logic          cs,
  input  logic          rw,
  output logic          miso_buff,
  output logic          dm_we,
  output logic          addr_we,
  output logic          sr_we,
  output logic          addr_inc,
  output logic          busy,
  output logic          abort,
  output logic [2:0]    state_dbg,
  output logic [CW-1:0] cnt_dbg
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE
  } state_t;

  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          count;
  // Set only when READ_LOAD is entered from a completed burst word, so the
  // first load after the header does not bump the address.
  logic          rd_inc, rd_inc_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_inc <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rd_inc <= rd_inc_n;
    end
  end

  always_comb begin
    state_n   = state;
    count     = 1'b0;
    rd_inc_n  = 1'b0;
    miso_buff = 1'b0;
    dm_we     = 1'b0;
    addr_we   = 1'b0;
    sr_we     = 1'b0;
    addr_inc  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (!cs) state_n = GET_ADDR;
      GET_ADDR: begin
        if (cs) begin
          state_n = IDLE;
          abort   = 1'b1;
        end else if (sclk_edge) begin
          if (cnt == ADDR_LAST) state_n = GOT_ADDR;
          else count = 1'b1;
        end
      end
      GOT_ADDR: begin
        if (cs) state_n = IDLE;
        else begin
          addr_we = 1'b1;
          state_n = rw ? READ_LOAD : WRITE_SHIFT;
        end
      end
      READ_LOAD: begin
        if (cs) state_n = IDLE;
        else begin
          sr_we    = 1'b1;
          addr_inc = rd_inc;
          state_n  = READ_SHIFT;
        end
      end
      READ_SHIFT: begin
        if (cs) begin
          state_n = IDLE;
          abort   = (cnt != '0);
        end else begin
          miso_buff = 1'b1;
          if (sclk_edge) begin
            if (cnt == DATA_LAST) begin
              if (BURST_EN != 0) begin
                state_n  = READ_LOAD;
                rd_inc_n = 1'b1;
              end else begin
                state_n = DONE;
              end
            end else begin
              count = 1'b1;
            end
          end
        end
      end
      WRITE_SHIFT: begin
        if (cs) begin
          state_n = IDLE;
          abort   = (cnt != '0);
        end else if (sclk_edge) begin
          if (cnt == DATA_LAST) state_n = WRITE_COMMIT;
          else count = 1'b1;
        end
      end
      WRITE_COMMIT: begin
        // The word is complete here, so it commits even if cs has just risen.
        dm_we = 1'b1;
        if (cs) state_n = IDLE;
        else begin
          addr_inc = (BURST_EN != 0);
          state_n  = (BURST_EN != 0) ? WRITE_SHIFT : DONE;
        end
      end
      DONE: if (cs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
    else if (count)       cnt_n = cnt + 1'b1;
    else                  cnt_n = cnt;
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign cnt_dbg   = cnt;

endmodule

// File: tb/tb_spi_slave_fsm_burst.sv
// Bench for spi_slave_fsm_burst: a non-burst and a burst instance share randomized SPI frames;
// a frame-level model predicts every cycle with a non-zero output and a monitor compares.
module tb_spi_slave_fsm_burst;
  localparam int A  = 7;
  localparam int D  = 8;
  localparam int W  = 27;

  logic clk = 1'b0;
  logic reset, sclk_edge, cs, rw;
  logic miso0, dm0, aw0, sr0, inc0, busy0, ab0;
  logic miso1, dm1, aw1, sr1, inc1, busy1, ab1;
  logic [2:0] st0, st1;
  logic [3:0] cnt0, cnt1;

  spi_slave_fsm_burst #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .BURST_EN(0)) dut_n (
    .clk(clk), .reset(reset), .sclk_edge(sclk_edge), .cs(cs), .rw(rw),
    .miso_buff(miso0), .dm_we(dm0), .addr_we(aw0), .sr_we(sr0), .addr_inc(inc0),
    .busy(busy0), .abort(ab0), .state_dbg(st0), .cnt_dbg(cnt0));

  spi_slave_fsm_burst #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .BURST_EN(1)) dut_b (
    .clk(clk), .reset(reset), .sclk_edge(sclk_edge), .cs(cs), .rw(rw),
    .miso_buff(miso1), .dm_we(dm1), .addr_we(aw1), .sr_we(sr1), .addr_inc(inc1),
    .busy(busy1), .abort(ab1), .state_dbg(st1), .cnt_dbg(cnt1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Entry = {cycle, busy, abort, addr_inc, sr_we, addr_we, dm_we, miso_buff}
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  int         e_off[64];
  int         n_eff, ch_off, c0;
  logic [6:0] mv[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_check(input int id, input logic [6:0] act);
    logic [W-1:0] ent;
    bit have;
    have = 1'b0;
    ent  = '0;
    if (id == 0) begin
      while (exp_q0.size() > 0 && int'(exp_q0[0][W-1:7]) < cyc) begin
        ent = exp_q0.pop_front();
        checks++; errors++;
        $display("FAIL mon0 missed cycle %0d expected %b", ent[W-1:7], ent[6:0]);
      end
      if (exp_q0.size() > 0 && int'(exp_q0[0][W-1:7]) == cyc) begin
        ent = exp_q0.pop_front(); have = 1'b1;
      end
    end else begin
      while (exp_q1.size() > 0 && int'(exp_q1[0][W-1:7]) < cyc) begin
        ent = exp_q1.pop_front();
        checks++; errors++;
        $display("FAIL mon1 missed cycle %0d expected %b", ent[W-1:7], ent[6:0]);
      end
      if (exp_q1.size() > 0 && int'(exp_q1[0][W-1:7]) == cyc) begin
        ent = exp_q1.pop_front(); have = 1'b1;
      end
    end
    if (have) begin
      checks++;
      if (act !== ent[6:0]) begin
        errors++;
        $display("FAIL mon%0d cycle %0d: got %b expected %b", id, cyc, act, ent[6:0]);
      end
    end else if (act !== 7'b0) begin
      checks++; errors++;
      $display("FAIL mon%0d cycle %0d: got %b expected 0000000", id, cyc, act);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_check(0, {busy0, ab0, inc0, sr0, aw0, dm0, miso0});
      mon_check(1, {busy1, ab1, inc1, sr1, aw1, dm1, miso1});
    end
  end

  // Frame-level reference: header is A+1 edges, then words of D edges; cs high at ch_off ends it.
  task automatic model(input int burst, input int rwbit);
    int ho, m, k, rem, nw, ld, endt;
    logic ab, keep_dm;
    for (int t = 0; t < 256; t++) mv[t] = 7'b0;
    for (int t = 1; t <= ch_off; t++) mv[t][6] = 1'b1;
    ab = 1'b0;
    if (n_eff < A + 1) begin
      ab = 1'b1;
    end else begin
      ho = e_off[A];
      mv[ho + 1][2] = 1'b1;
      m   = n_eff - (A + 1);
      k   = m / D;
      if (burst == 0 && k > 1) k = 1;
      rem = (burst == 0 && m >= D) ? 0 : (m % D);
      ab  = (rem != 0);
      if (rwbit == 0) begin
        for (int j = 1; j <= k; j++) begin
          mv[e_off[A + j * D] + 1][1] = 1'b1;
          if (burst != 0) mv[e_off[A + j * D] + 1][4] = 1'b1;
        end
      end else begin
        nw = (burst != 0) ? k + 1 : 1;
        for (int j = 1; j <= nw; j++) begin
          ld = (j == 1) ? ho + 2 : e_off[A + (j - 1) * D] + 1;
          if (ld >= ch_off) break;
          mv[ld][3] = 1'b1;
          if (j > 1) mv[ld][4] = 1'b1;
          endt = (j <= k) ? e_off[A + j * D] : ch_off - 1;
          if (endt > ch_off - 1) endt = ch_off - 1;
          for (int t = ld + 1; t <= endt; t++) mv[t][0] = 1'b1;
        end
      end
    end
    keep_dm = mv[ch_off][1];
    mv[ch_off] = {1'b1, ab, 3'b000, keep_dm, 1'b0};
    for (int t = 0; t <= ch_off; t++) begin
      if (mv[t] != 7'b0) begin
        if (burst == 0) exp_q0.push_back({20'(c0 + t), mv[t]});
        else            exp_q1.push_back({20'(c0 + t), mv[t]});
      end
    end
  endtask

  task automatic drive(input logic cs_v, input logic e_v, input logic rw_v);
    @(posedge clk);
    #1;
    cs = cs_v; sclk_edge = e_v; rw = rw_v;
  endtask

  // gap 0: cs rises together with the last edge; otherwise cs rises gap clks after it.
  task automatic run_frame(input int rwbit, input int nedges, input int gap);
    int t, idx, seen;
    logic e_v, rw_v;
    if (nedges == 0 && gap == 0) gap = 2;
    c0 = cyc + 1;
    t  = 0;
    for (int i = 0; i < nedges; i++) begin
      t += $urandom_range(4, 6);
      e_off[i] = t;
    end
    if (gap == 0) begin
      ch_off = e_off[nedges - 1];
      n_eff  = nedges - 1;
    end else begin
      ch_off = ((nedges > 0) ? e_off[nedges - 1] : 0) + gap;
      n_eff  = nedges;
    end
    model(0, rwbit);
    model(1, rwbit);
    idx  = 0;
    seen = 0;
    for (int c = 0; c <= ch_off; c++) begin
      e_v = (idx < nedges && e_off[idx] == c);
      if (e_v) begin idx++; seen++; end
      rw_v = (seen == A + 1) ? 1'(rwbit) : 1'($urandom_range(0, 1));
      drive(c == ch_off, e_v, rw_v);
    end
    repeat (3) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; sclk_edge = 1'b0; rw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_n", {25'b0, busy0, ab0, inc0, sr0, aw0, dm0, miso0}, 32'h0);
    chk("reset_out_b", {25'b0, busy1, ab1, inc1, sr1, aw1, dm1, miso1}, 32'h0);
    chk("reset_cnt_n", {28'b0, cnt0}, 32'h0);
    chk("reset_cnt_b", {28'b0, cnt1}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    run_frame(0, 16, 2);
    run_frame(1, 16, 2);
    run_frame(0, 32, 2);
    run_frame(1, 24, 2);
    run_frame(0, 12, 2);
    run_frame(0, 16, 3);
    for (int f = 0; f < 40; f++) begin
      run_frame($urandom_range(0, 1), $urandom_range(0, 36), (f % 3 == 0) ? 0 : $urandom_range(2, 3));
    end
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    chk("queue_empty_n", exp_q0.size(), 32'h0);
    chk("queue_empty_b", exp_q1.size(), 32'h0);
    mon_en = 1'b0;

    // Asynchronous reset in the middle of a read word.
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < A + 4; i++) begin
      repeat (3) drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
    end
    repeat (2) drive(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_reset_miso_n", {31'b0, miso0}, 32'h1);
    chk("pre_reset_miso_b", {31'b0, miso1}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("async_miso_n", {31'b0, miso0}, 32'h0);
    chk("async_miso_b", {31'b0, miso1}, 32'h0);
    chk("async_busy_n", {31'b0, busy0}, 32'h0);
    chk("async_busy_b", {31'b0, busy1}, 32'h0);
    cs = 1'b1; sclk_edge = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy_n", {31'b0, busy0}, 32'h0);
    chk("post_reset_busy_b", {31'b0, busy1}, 32'h0);
    chk("post_reset_cnt_n", {28'b0, cnt0}, 32'h0);
    chk("post_reset_cnt_b", {28'b0, cnt1}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm_burst.md
Name: spi_slave_fsm_burst

Overview:
Parametrised control FSM for the SPI slave datapath. It is the successor to the fixed 7-bit-address / 8-bit-data slave controller.
- Counts synchronised SCLK sampling edges, decodes the address + R/W header and sequences the address latch, shift-register load, MISO tristate enable and data-memory write.
- Adds configurable address/data widths, optional burst (auto-increment) transfers and an abort indication.
- Sits between the input synchronisers/edge detectors and the address latch, shift register and data memory.

Parameters:
ADDR_WIDTH, 7, address bits shifted in before the R/W bit (1..15)
DATA_WIDTH, 8, data bits per word (1..32)
BURST_EN, 1, 1: keep transferring consecutive words while cs stays low; 0: one word per frame

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sclk_edge  input  1  one-clk pulse at each SCLK sampling (rising) edge, already synchronised
cs  input  1  chip select, active low, already synchronised
rw  input  1  shift register parallel-out LSB; 1 = read, 0 = write; sampled in GOT_ADDR
miso_buff  output  1  MISO tristate enable
dm_we  output  1  data memory write enable, one-clk pulse
addr_we  output  1  address latch write enable, one-clk pulse
sr_we  output  1  shift register parallel-load enable, one-clk pulse
addr_inc  output  1  address latch increment, one-clk pulse (burst only)
busy  output  1  high whenever state != IDLE
abort  output  1  one-clk pulse when cs rises mid-word

Behaviour:
- Reset (async, any state): state=IDLE, bit counter=0. All outputs 0 on assertion, before the next clk edge.
- Bit counter is $clog2(max(ADDR_WIDTH+1, DATA_WIDTH)+1) bits wide. It clears on every state entry and increments on sclk_edge only in counting states.
- IDLE: all outputs 0. When cs=0, go to GET_ADDR next clk.
- GET_ADDR: count sclk_edge. On the (ADDR_WIDTH+1)th edge, go to GOT_ADDR.
- GOT_ADDR (1 clk): addr_we=1. Sample rw:
  - rw=1: go to READ_LOAD.
  - rw=0: go to WRITE_SHIFT.
- READ_LOAD (1 clk): sr_we=1, then go to READ_SHIFT.
- READ_SHIFT: miso_buff=1. On the DATA_WIDTHth edge:
  - BURST_EN=1: addr_inc=1 for 1 clk, then go to READ_LOAD.
  - BURST_EN=0: go to DONE.
- WRITE_SHIFT: count DATA_WIDTH edges, then go to WRITE_COMMIT.
- WRITE_COMMIT (1 clk): dm_we=1. In the same cycle, addr_inc=1 if BURST_EN; memory writes the pre-increment address.
  - BURST_EN=1: return to WRITE_SHIFT.
  - BURST_EN=0: go to DONE.
- Read-side addr_inc is asserted during the READ_LOAD that follows the DATA_WIDTHth edge. The increment and the load of the next word therefore coincide; the address latch presents the incremented address one clk later. The load uses the registered memory output of the new address, and the datapath owns that timing.
- DONE: all outputs 0, busy=1. Ignore sclk_edge. When cs=1, go to IDLE.
- cs=1 in any non-IDLE state takes priority over every other transition: go to IDLE next clk, all outputs 0 in that cycle.
  - abort=1 for that cycle if the state is GET_ADDR, or the state is READ_SHIFT/WRITE_SHIFT with bit counter != 0.
  - A partially shifted write word is never committed.
- cs=1 while in WRITE_COMMIT: dm_we still asserts that cycle (the word is complete), then IDLE.
- sclk_edge during a 1-clk state (GOT_ADDR, READ_LOAD, WRITE_COMMIT) is ignored, not counted. The system requirement is SCLK period >= 4 clk, so this cannot occur in legal operation.
- sclk_edge and cs rising in the same cycle: cs wins; the edge is not counted.
- At most one of dm_we, addr_we, sr_we is high in any cycle.

Test Plan:
- BURST_EN=0, write 0xFF to addr 0x00: cs low, 7 edges rw=0, 8th edge rw=0, 8 data edges -> addr_we 1 clk after edge 8; dm_we exactly 1 clk after edge 16; miso_buff never high; DONE until cs high.
- BURST_EN=0, read addr 0x00: rw=1 at GOT_ADDR -> addr_we after edge 8, sr_we next clk, miso_buff high from then until 1 clk after edge 16; dm_we never high.
- BURST_EN=1, 3-word write -> dm_we and addr_inc each pulse 3 times, after edges 16, 24 and 32; cs high after edge 32 -> IDLE, abort=0.
- BURST_EN=1, 2-word read -> sr_we after edges 8 and 16; addr_inc after edge 16; miso_buff stays high apart from the 1-clk sr_we cycle; cs high after edge 24 -> abort=0.
- Write aborted: cs high after 12 edges -> abort pulse 1 clk, no dm_we, IDLE; new frame afterwards runs normally.
- reset asserted mid READ_SHIFT -> miso_buff/busy drop to 0 without a clk edge; after release, state IDLE and counter 0.
